// File: rtl/gpio_defaults_sequencer.sv
// Power-on GPIO configuration sequencer: holds per-channel shadow words, takes run-time
// overrides, and shifts every word into the pad-ring chain before pulsing its load strobe.
// Optional chain-tail readback checking is enabled with `define GPIO_DEFAULTS_READBACK_EN.
module gpio_defaults_sequencer #(
    parameter int NUM_CHANNELS = 19,
    parameter int CONFIG_WIDTH = 10,
    parameter logic [NUM_CHANNELS*CONFIG_WIDTH-1:0] CONFIG_INIT = {NUM_CHANNELS{10'h007}},
    parameter int CLK_DIV = 2
) (
    input  logic                                   wb_clk_i,
    input  logic                                   wb_rst_i,
    input  logic                                   start_i,
    input  logic                                   ovr_valid_i,
    output logic                                   ovr_ready_o,
    input  logic [$clog2(NUM_CHANNELS):0]          ovr_chan_i,
    input  logic [CONFIG_WIDTH-1:0]                ovr_data_i,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic                                   serial_clock_o,
    output logic                                   serial_data_o,
    output logic                                   serial_load_o,
`ifdef GPIO_DEFAULTS_READBACK_EN
    input  logic                                   serial_data_i,
    output logic                                   readback_err_o,
`endif
    output logic [NUM_CHANNELS*CONFIG_WIDTH-1:0]   gpio_defaults_o
);

    localparam int TOTAL_BITS = NUM_CHANNELS * CONFIG_WIDTH;
    localparam int CHAN_W     = $clog2(NUM_CHANNELS) + 1;
    localparam int BIT_W      = (TOTAL_BITS > 1) ? $clog2(TOTAL_BITS) : 1;
    localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(TOTAL_BITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT_LO = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_LOAD_GAP = 3'd3,
        ST_LOAD     = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    // Bit idx of the stream: flattened MSB is channel N-1's MSB, so stream order is top-down.
    function automatic logic stream_bit(input logic [TOTAL_BITS-1:0] word,
                                        input logic [BIT_W-1:0]      idx);
        stream_bit = word[LAST_BIT - idx];
    endfunction

    state_t                  state_r;
    state_t                  state_next_s;
    logic [DIV_W-1:0]        div_r;
    logic [DIV_W-1:0]        div_next_s;
    logic [BIT_W-1:0]        bit_r;
    logic [BIT_W-1:0]        bit_next_s;
    logic                    pending_r;
    logic                    start_seq_s;
    logic [TOTAL_BITS-1:0]   shadow_r;
    logic [TOTAL_BITS-1:0]   shadow_next_s;
    logic [TOTAL_BITS-1:0]   snap_r;
    logic [TOTAL_BITS-1:0]   snap_src_s;
    logic                    ovr_fire_s;
    logic                    div_end_s;
    logic                    last_bit_s;

    logic busy_r, done_r, sclk_r, sdata_r, sload_r, ready_r;
    logic busy_next_s, done_next_s, sclk_next_s, sdata_next_s, sload_next_s, ready_next_s;

    assign ovr_fire_s = ovr_valid_i && ready_r;
    assign div_end_s  = (div_r == DIV_LAST);
    assign last_bit_s = (bit_r == LAST_BIT);
    assign snap_src_s = start_seq_s ? shadow_next_s : snap_r;

    // Apply an accepted override; out-of-range channels match no slot and are dropped.
    always_comb begin
        shadow_next_s = shadow_r;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            shadow_next_s[c*CONFIG_WIDTH +: CONFIG_WIDTH] =
                (ovr_fire_s && (ovr_chan_i == CHAN_W'(c))) ? ovr_data_i
                                                           : shadow_r[c*CONFIG_WIDTH +: CONFIG_WIDTH];
        end
    end

    // Next-state, counter and registered-output next values.
    always_comb begin
        state_next_s = state_r;
        div_next_s   = div_r + DIV_W'(1);
        bit_next_s   = bit_r;
        start_seq_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                div_next_s = '0;
                bit_next_s = '0;
                if (start_i || pending_r) begin
                    state_next_s = ST_SHIFT_LO;
                    start_seq_s  = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT_LO: begin
                if (div_end_s) begin
                    state_next_s = ST_SHIFT_HI;
                    div_next_s   = '0;
                end else begin
                    state_next_s = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_HI: begin
                if (div_end_s) begin
                    div_next_s = '0;
                    if (last_bit_s) begin
                        state_next_s = ST_LOAD_GAP;
                        bit_next_s   = '0;
                    end else begin
                        state_next_s = ST_SHIFT_LO;
                        bit_next_s   = bit_r + BIT_W'(1);
                    end
                end else begin
                    state_next_s = ST_SHIFT_HI;
                end
            end
            ST_LOAD_GAP: begin
                if (div_end_s) begin
                    state_next_s = ST_LOAD;
                    div_next_s   = '0;
                end else begin
                    state_next_s = ST_LOAD_GAP;
                end
            end
            ST_LOAD: begin
                if (div_end_s) begin
                    state_next_s = ST_DONE;
                    div_next_s   = '0;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
                div_next_s   = '0;
            end
            default: begin
                state_next_s = ST_IDLE;
                div_next_s   = '0;
                bit_next_s   = '0;
            end
        endcase

        // Outputs are registered from the next state so they line up with the state register.
        busy_next_s  = (state_next_s != ST_IDLE);
        ready_next_s = (state_next_s == ST_IDLE);
        done_next_s  = (state_next_s == ST_DONE);
        sclk_next_s  = (state_next_s == ST_SHIFT_HI);
        sload_next_s = (state_next_s == ST_LOAD);
        if ((state_next_s == ST_SHIFT_LO) || (state_next_s == ST_SHIFT_HI)) begin
            sdata_next_s = stream_bit(snap_src_s, bit_next_s);
        end else begin
            sdata_next_s = 1'b0;
        end
    end

    // State, counters, shadow/snapshot storage and registered outputs.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r   <= ST_IDLE;
            div_r     <= '0;
            bit_r     <= '0;
            pending_r <= 1'b1;
            shadow_r  <= CONFIG_INIT;
            snap_r    <= CONFIG_INIT;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            sclk_r    <= 1'b0;
            sdata_r   <= 1'b0;
            sload_r   <= 1'b0;
            ready_r   <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            div_r     <= div_next_s;
            bit_r     <= bit_next_s;
            pending_r <= pending_r && !start_seq_s;
            shadow_r  <= shadow_next_s;
            snap_r    <= snap_src_s;
            busy_r    <= busy_next_s;
            done_r    <= done_next_s;
            sclk_r    <= sclk_next_s;
            sdata_r   <= sdata_next_s;
            sload_r   <= sload_next_s;
            ready_r   <= ready_next_s;
        end
    end

    assign busy_o          = busy_r;
    assign done_o          = done_r;
    assign serial_clock_o  = sclk_r;
    assign serial_data_o   = sdata_r;
    assign serial_load_o   = sload_r;
    assign ovr_ready_o     = ready_r;
    assign gpio_defaults_o = shadow_r;

`ifdef GPIO_DEFAULTS_READBACK_EN
    // The chain tail presents the previous sequence's bit k just before the k-th rising clock.
    logic [TOTAL_BITS-1:0] prev_snap_r;
    logic                  have_prev_r;
    logic                  rb_err_r;
    logic                  rb_sample_s;

    assign rb_sample_s = have_prev_r && (state_r == ST_SHIFT_LO) && (state_next_s == ST_SHIFT_HI);

    // Readback history and sticky mismatch flag.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            prev_snap_r <= '0;
            have_prev_r <= 1'b0;
            rb_err_r    <= 1'b0;
        end else begin
            if (state_r == ST_DONE) begin
                prev_snap_r <= snap_r;
                have_prev_r <= 1'b1;
            end else begin
                prev_snap_r <= prev_snap_r;
                have_prev_r <= have_prev_r;
            end
            if (rb_sample_s && (serial_data_i != stream_bit(prev_snap_r, bit_r))) begin
                rb_err_r <= 1'b1;
            end else begin
                rb_err_r <= rb_err_r;
            end
        end
    end

    assign readback_err_o = rb_err_r;
`endif

endmodule
